// File: rtl/conv_addr_gen.sv
// Convolution SRAM address generator: turns one packed multi-slice instruction
// into a burst of per-slice strided addresses under valid/ready handshakes.
module conv_addr_gen #(
    parameter int IRW = 30,
    parameter int IN  = 3,
    parameter int AW  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IRW*IN-1:0] m_inst,
    input  logic              m_valid,
    output logic              m_ready,
    output logic [AW*IN-1:0]  s_addr,
    output logic [IN-1:0]     s_en,
    output logic              s_last,
    output logic              s_eol,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              busy
);

    localparam int SW = 7;
    localparam int LW = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IN-1:0][AW-1:0]   addr_q, addr_d;
    logic [IN-1:0][SW-1:0]   stride_q, stride_d;
    logic [IN-1:0]           en_q, en_d;
    logic                    eol_q, eol_d;
    logic [LW-1:0]           cnt_q, cnt_d;

    logic [IN-1:0]           inst_en;
    logic [IN-1:0][AW-1:0]   inst_base;
    logic [IN-1:0][SW-1:0]   inst_stride;
    logic [LW-1:0]           inst_len;
    logic                    inst_eol;

    logic                    m_fire;
    logic                    s_fire;
    logic                    run_st;

    // Field unpacking; len and eol are only meaningful in slice 0.
    assign inst_len = m_inst[AW+8 +: LW];
    assign inst_eol = m_inst[IRW-1];

    for (genvar gi = 0; gi < IN; gi++) begin : g_slice
        assign inst_en[gi]     = m_inst[IRW*gi];
        assign inst_base[gi]   = m_inst[IRW*gi+1 +: AW];
        assign inst_stride[gi] = m_inst[IRW*gi+AW+1 +: SW];
        if (gi > 0) begin : g_hi_unused
            logic unused_len_eol;
            assign unused_len_eol = ^{m_inst[IRW*gi+AW+8 +: LW], m_inst[IRW*gi+IRW-1]};
        end
        if (IRW > AW + 16) begin : g_gap_unused
            logic unused_gap;
            assign unused_gap = ^m_inst[IRW*gi+AW+15 +: IRW-AW-16];
        end
    end

    assign run_st  = (state_q == RUN);
    assign s_valid = run_st;
    assign busy    = run_st;
    assign s_last  = run_st && (cnt_q == '0);
    assign s_eol   = s_last && eol_q;
    assign s_en    = en_q;
    assign s_addr  = addr_q;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign m_ready = !rst && (!run_st || (s_ready && s_last));
    assign m_fire  = m_valid && m_ready;
    assign s_fire  = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        en_d     = en_q;
        eol_d    = eol_q;
        cnt_d    = cnt_q;

        if (s_fire) begin
            for (int k = 0; k < IN; k++) begin
                addr_d[k] = addr_q[k] + {{(AW-SW){1'b0}}, stride_q[k]};
            end
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // A zero-length instruction is consumed without touching any state.
        if (m_fire && (inst_len != '0)) begin
            state_d  = RUN;
            addr_d   = inst_base;
            stride_d = inst_stride;
            en_d     = inst_en;
            eol_d    = inst_eol;
            cnt_d    = inst_len - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            en_q     <= '0;
            eol_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            en_q     <= en_d;
            eol_q    <= eol_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: each task drives one scenario and checks
// outputs on the falling edge against hand-computed values.
module tb_conv_addr_gen;

    localparam int IRW = 30;
    localparam int IN  = 3;
    localparam int AW  = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [IRW*IN-1:0] m_inst;
    logic              m_valid;
    logic              m_ready;
    logic [AW*IN-1:0]  s_addr;
    logic [IN-1:0]     s_en;
    logic              s_last;
    logic              s_eol;
    logic              s_valid;
    logic              s_ready;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    conv_addr_gen #(.IRW(IRW), .IN(IN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .m_inst(m_inst), .m_valid(m_valid), .m_ready(m_ready),
        .s_addr(s_addr), .s_en(s_en), .s_last(s_last), .s_eol(s_eol),
        .s_valid(s_valid), .s_ready(s_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [IRW-1:0] mk(input logic en, input logic [13:0] base,
                                          input logic [6:0] stride, input logic [6:0] len,
                                          input logic eol);
        logic [IRW-1:0] r;
        r = '0;
        r[0] = en;
        r[14:1] = base;
        r[21:15] = stride;
        r[28:22] = len;
        r[29] = eol;
        return r;
    endfunction

    // {valid,last,eol,busy,m_ready,addr0}
    function automatic logic [18:0] obs();
        return {s_valid, s_last, s_eol, busy, m_ready, s_addr[13:0]};
    endfunction

    function automatic logic [18:0] ex(input logic v, input logic l, input logic e,
                                       input logic b, input logic r, input logic [13:0] a);
        return {v, l, e, b, r, a};
    endfunction

    task automatic test_reset();
        rst = 1'b1; m_valid = 1'b0; m_inst = '0; s_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_valid, s_last, s_eol, busy, m_ready, s_en, s_addr} !== '0) begin
            $display("FAIL reset_state got v=%b l=%b e=%b busy=%b mr=%b en=%b addr=%h want all zero",
                     s_valid, s_last, s_eol, busy, m_ready, s_en, s_addr);
            failures++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ready !== 1'b1 || s_valid !== 1'b0) begin
            $display("FAIL reset_release got mr=%b v=%b want mr=1 v=0", m_ready, s_valid);
            failures++;
        end
    endtask

    task automatic test_basic();
        logic [18:0] want;
        m_inst  = {mk(1'b1, 14'h200, 7'd0, 7'd0, 1'b0),
                   mk(1'b0, 14'h100, 7'd2, 7'd0, 1'b0),
                   mk(1'b1, 14'h010, 7'd1, 7'd4, 1'b0)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        m_inst  = '1;
        for (int j = 0; j < 4; j++) begin
            want = ex(1'b1, j == 3, 1'b0, 1'b1, j == 3, 14'h010 + 14'(j));
            checks++;
            if (obs() !== want || s_en !== 3'b101 || s_addr[27:14] !== 14'h100 + 14'(2*j)
                || s_addr[41:28] !== 14'h200) begin
                $display("FAIL basic_beat%0d got obs=%h en=%b addr=%h want obs=%h en=101 a1=%h a2=200",
                         j, obs(), s_en, s_addr, want, 14'h100 + 14'(2*j));
                failures++;
            end
            @(negedge clk);
        end
        checks++;
        if (s_valid !== 1'b0 || busy !== 1'b0 || m_ready !== 1'b1) begin
            $display("FAIL basic_done got v=%b busy=%b mr=%b want 0 0 1", s_valid, busy, m_ready);
            failures++;
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] exp_a [6] = '{14'd0, 14'd7, 14'd7, 14'd7, 14'd14, 14'd0};
        logic        exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        rdy   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [18:0] want;
        m_inst  = {60'd0, mk(1'b1, 14'd0, 7'd7, 7'd3, 1'b0)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            s_ready = rdy[c];
            want = ex(exp_v[c], c == 4, 1'b0, exp_v[c], (c == 4) || (c == 5), exp_a[c]);
            if (c == 5) want[13:0] = s_addr[13:0];
            checks++;
            if (obs() !== want) begin
                $display("FAIL backpressure_cyc%0d got obs=%h want %h", c, obs(), want);
                failures++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp_a [3] = '{14'h3FFE, 14'h0001, 14'h0004};
        m_inst  = {60'd0, mk(1'b1, 14'h3FFE, 7'd3, 7'd3, 1'b0)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (s_valid !== 1'b1 || s_addr[13:0] !== exp_a[j] || s_last !== (j == 2)) begin
                $display("FAIL wrap_beat%0d got v=%b a=%h l=%b want v=1 a=%h l=%b",
                         j, s_valid, s_addr[13:0], s_last, exp_a[j], j == 2);
                failures++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] want;
        m_inst  = {60'd0, mk(1'b1, 14'h020, 7'd1, 7'd2, 1'b0)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        m_inst = {60'd0, mk(1'b1, 14'h040, 7'd1, 7'd1, 1'b1)};
        want = ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'h020);
        checks++;
        if (obs() !== want) begin
            $display("FAIL b2b_beat1 got obs=%h want %h", obs(), want);
            failures++;
        end
        @(negedge clk);
        want = ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h021);
        checks++;
        if (obs() !== want) begin
            $display("FAIL b2b_beat2 got obs=%h want %h", obs(), want);
            failures++;
        end
        @(negedge clk);
        m_valid = 1'b0;
        want = ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 14'h040);
        checks++;
        if (obs() !== want) begin
            $display("FAIL b2b_beat3 got obs=%h want %h", obs(), want);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL b2b_done got v=%b busy=%b want 0 0", s_valid, busy);
            failures++;
        end
    endtask

    task automatic test_zero_len();
        m_inst  = {60'd0, mk(1'b1, 14'h033, 7'd1, 7'd0, 1'b1)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0 || busy !== 1'b0 || m_ready !== 1'b1) begin
            $display("FAIL zero_len_drop got v=%b busy=%b mr=%b want 0 0 1", s_valid, busy, m_ready);
            failures++;
        end
        m_inst = {60'd0, mk(1'b1, 14'h055, 7'd1, 7'd1, 1'b0)};
        @(negedge clk);
        m_valid = 1'b0;
        checks++;
        if (obs() !== ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h055)) begin
            $display("FAIL zero_len_next got obs=%h want %h", obs(), ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h055));
            failures++;
        end
        @(negedge clk);
        checks++;
        if (s_valid !== 1'b0) begin
            $display("FAIL zero_len_single got v=%b want 0", s_valid);
            failures++;
        end
    endtask

    task automatic test_reset_mid_run();
        m_inst  = {60'd0, mk(1'b1, 14'd0, 7'd1, 7'd10, 1'b1)};
        m_valid = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (s_valid !== 1'b1 || s_addr[13:0] !== 14'(j) || s_last !== 1'b0) begin
                $display("FAIL rstrun_beat%0d got v=%b a=%h l=%b want v=1 a=%h l=0",
                         j, s_valid, s_addr[13:0], s_last, j);
                failures++;
            end
            if (j < 3) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_valid, busy, m_ready, s_en, s_addr} !== '0) begin
            $display("FAIL rstrun_in_reset got v=%b busy=%b mr=%b en=%b addr=%h want all zero",
                     s_valid, busy, m_ready, s_en, s_addr);
            failures++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (s_valid !== 1'b0 || m_ready !== 1'b1) begin
                $display("FAIL rstrun_after%0d got v=%b mr=%b want v=0 mr=1", c, s_valid, m_ready);
                failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_zero_len();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 Parameter IRW, default 30, width of one instruction slice.
REQ-002 Parameter IN, default 3, number of slices per packed instruction (slice 0 = input feature, 1 = weight, 2 = output).
REQ-003 Parameter AW, default 14, SRAM word-address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 m_inst  input  IRW*IN  packed instruction from the upstream conv instruction-loop stage; slice k = m_inst[IRW*k +: IRW].
REQ-007 m_valid  input  1  upstream instruction valid.
REQ-008 m_ready  output  1  this block accepts m_inst.
REQ-009 s_addr  output  AW*IN  per-slice read/write address, slice k at s_addr[AW*k +: AW].
REQ-010 s_en  output  IN  per-slice enable, copied from slice enable bits.
REQ-011 s_last  output  1  marks final beat of the current instruction.
REQ-012 s_eol  output  1  marks final beat of an instruction whose end-of-layer flag is set.
REQ-013 s_valid  output  1  beat valid.
REQ-014 s_ready  input  1  downstream accepts beat.
REQ-015 busy  output  1  high while state is RUN.

Function
REQ-016 Slice field layout: bit 0 en; bits [AW:1] base; bits [AW+7:AW+1] stride (7b); bits [AW+14:AW+8] len (7b, slice 0 only significant); bit IRW-1 eol (slice 0 only significant).
REQ-017 Transfer on either port occurs only in a cycle where valid and ready are both high.
REQ-018 FSM states: IDLE, RUN.
REQ-019 IDLE -> RUN on accepted instruction with len != 0; accepted instruction with len == 0 is dropped, with no beat emitted and the block staying in IDLE.
REQ-020 RUN -> IDLE when the s_last beat is accepted and no new instruction is accepted in that cycle.
REQ-021 RUN -> RUN, reloaded, when the s_last beat is accepted and a new instruction with len != 0 is accepted in the same cycle (back-to-back, no bubble).
REQ-022 m_ready = (state == IDLE) OR (s_valid AND s_ready AND s_last); m_ready is combinational from registered state and s_ready only.
REQ-023 Latency: instruction accepted at cycle t gives its first beat with s_valid = 1 at cycle t+1.
REQ-024 Beat j (0 <= j < len) SHALL carry s_addr slice k = (base_k + j*stride_k) mod 2^AW, produced by a per-slice accumulator that adds the zero-extended stride on each accepted beat; no multiplier is used.
REQ-025 Address wrap-around modulo 2^AW SHALL occur silently, with no flag.
REQ-026 A beat-remaining counter SHALL load len-1 on accept and decrement on each accepted beat; s_last = 1 when the counter == 0.
REQ-027 s_eol = s_last AND latched eol; s_en = latched en bits and is constant across all beats of one instruction.
REQ-028 While s_valid = 1 and s_ready = 0, s_addr, s_en, s_last, s_eol SHALL hold stable.
REQ-029 s_valid SHALL be 1 exactly while state is RUN; one beat per cycle when s_ready is held high.
REQ-030 Slices with en = 0 still advance their addresses; downstream ignores them.
REQ-031 m_inst is sampled only on acceptance; changes at other times have no effect.

Reset
REQ-032 On rst = 1 at a clock edge: state = IDLE, s_valid = 0, s_last = 0, s_eol = 0, s_en = 0, s_addr = 0, counter = 0, busy = 0.
REQ-033 Reset asserted mid-instruction SHALL abort it; no remaining beats are emitted after reset releases.
REQ-034 m_ready SHALL be 0 during reset cycles and 1 in the first cycle after reset release.

Verification
REQ-035 Basic: slice0 base = 0x0010, stride = 1, len = 4, eol = 0, s_ready = 1 -> slice0 addresses 0x10, 0x11, 0x12, 0x13 on cycles t+1..t+4; s_last only on 0x13; s_eol = 0.
REQ-036 Backpressure: len = 3, stride = 7, base = 0; s_ready low 2 cycles on beat 1 -> beat 1 holds address 7 stable; sequence is 0, 7, 14 with no loss or duplication.
REQ-037 Wrap: base = 0x3FFE, stride = 3, len = 3, AW = 14 -> addresses 0x3FFE, 0x0001, 0x0004.
REQ-038 Back-to-back: instr A (len = 2, eol = 0), then instr B (len = 1, eol = 1) presented continuously -> 3 consecutive valid beats with no bubble; s_last on beats 2 and 3; s_eol only on beat 3.
REQ-039 Zero length: len = 0 instruction -> m_ready stays 1, no s_valid, busy = 0; a following len = 1 instruction emits one beat.
REQ-040 Reset mid-run: len = 10, rst asserted after beat 4 -> s_valid = 0 next cycle; no further beats; m_ready = 1 after release.
